// File: rtl/pix_clkgen_dds.sv
// Multi-channel DDS pixel-clock generator: per-channel phase accumulator drives a ce pulse
// train and a ~50% clkout; rate changes apply at a wrap. Define PIX_CLKGEN_PHASE_EN to add cfg_phase.
module pix_clkgen_dds #(
  parameter int NCH = 2,
  parameter int ACC_W = 24,
  parameter int LOCK_CYCLES = 16,
  parameter logic [ACC_W-1:0] DEFAULT_INC = 24'h400000,
  localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clkin,
  input  logic             reset,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [ACC_W-1:0] cfg_inc,
`ifdef PIX_CLKGEN_PHASE_EN
  input  logic [ACC_W-1:0] cfg_phase,
`endif
  output logic [NCH-1:0]   ce,
  output logic [NCH-1:0]   clkout,
  output logic [NCH-1:0]   lock
);

  // state      | meaning
  // ST_LOCKED  | rate settled, lock high, holding
  // ST_PENDING | new increment captured, waiting for the next wrap to apply it
  // ST_SETTLE  | new rate running, counting ce pulses until LOCK_CYCLES
  typedef enum logic [1:0] {
    ST_LOCKED  = 2'd0,
    ST_PENDING = 2'd1,
    ST_SETTLE  = 2'd2
  } state_t;

  logic [NCH-1:0] pend_nxt;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] inc_q, inc_d;
    logic [ACC_W-1:0] pend_q, pend_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             lock_q, lock_d;
    logic             skip_q, skip_d;
    logic             ce_q, clk_q;
    logic [ACC_W:0]   sum;
    logic             accept;
`ifdef PIX_CLKGEN_PHASE_EN
    logic [ACC_W-1:0] ph_q, ph_d;
`endif

    assign accept = cfg_valid & cfg_ready & (cfg_ch == CH_W'(i));
    assign sum    = {1'b0, acc_q} + {1'b0, inc_q};

    always_comb begin
      state_d = state_q;
      acc_d   = sum[ACC_W-1:0];
      inc_d   = inc_q;
      pend_d  = pend_q;
      cnt_d   = cnt_q;
      lock_d  = lock_q;
      skip_d  = 1'b0;
`ifdef PIX_CLKGEN_PHASE_EN
      ph_d    = ph_q;
`endif
      if (accept) begin
        pend_d  = cfg_inc;
`ifdef PIX_CLKGEN_PHASE_EN
        ph_d    = cfg_phase;
`endif
        lock_d  = 1'b0;
        cnt_d   = '0;
        state_d = ST_PENDING;
      end else begin
        case (state_q)
          // a zero increment never wraps, so it must not block the apply
          ST_PENDING: begin
            if (sum[ACC_W] || (inc_q == '0)) begin
              inc_d   = pend_q;
              skip_d  = 1'b1;
              state_d = ST_SETTLE;
`ifdef PIX_CLKGEN_PHASE_EN
              acc_d   = ph_q;
`endif
            end
          end
          ST_SETTLE: begin
            // skip_q masks the ce produced by the apply-cycle carry
            if (ce_q && !skip_q) begin
              cnt_d = cnt_q + 8'd1;
              if (cnt_d == 8'(LOCK_CYCLES)) begin
                lock_d  = 1'b1;
                state_d = ST_LOCKED;
              end
            end
          end
          default: ;
        endcase
      end
    end

    always_ff @(posedge clkin) begin
      if (reset) begin
        state_q <= ST_SETTLE;
        acc_q   <= '0;
        inc_q   <= DEFAULT_INC;
        pend_q  <= '0;
        cnt_q   <= '0;
        lock_q  <= 1'b0;
        skip_q  <= 1'b0;
        ce_q    <= 1'b0;
        clk_q   <= 1'b0;
`ifdef PIX_CLKGEN_PHASE_EN
        ph_q    <= '0;
`endif
      end else begin
        state_q <= state_d;
        acc_q   <= acc_d;
        inc_q   <= inc_d;
        pend_q  <= pend_d;
        cnt_q   <= cnt_d;
        lock_q  <= lock_d;
        skip_q  <= skip_d;
        ce_q    <= sum[ACC_W];
        clk_q   <= sum[ACC_W-1];
`ifdef PIX_CLKGEN_PHASE_EN
        ph_q    <= ph_d;
`endif
      end
    end

    assign pend_nxt[i] = (state_d == ST_PENDING);
    assign ce[i]       = ce_q;
    assign clkout[i]   = clk_q;
    assign lock[i]     = lock_q;
  end

  // ready follows the next-state view so it drops right after an accept
  always_ff @(posedge clkin) begin
    if (reset) cfg_ready <= 1'b0;
    else       cfg_ready <= ~|pend_nxt;
  end

endmodule

// File: tb/tb_pix_clkgen_dds.sv
// Scoreboard bench for pix_clkgen_dds: a cycle model pushes expected outputs at each
// rising edge; scenario tasks pop and compare on the falling edge, plus timing spot checks.
module tb_pix_clkgen_dds;
  localparam int NCH = 3;
  localparam int ACC_W = 24;
  localparam int LOCK_CYCLES = 16;
  localparam logic [ACC_W-1:0] DEF = 24'h400000;
  localparam int VW = 1 + 3*NCH;

  logic             clkin = 1'b0;
  logic             reset = 1'b1;
  logic             cfg_valid = 1'b0;
  logic             cfg_ready;
  logic [1:0]       cfg_ch = '0;
  logic [ACC_W-1:0] cfg_inc = '0;
`ifdef PIX_CLKGEN_PHASE_EN
  logic [ACC_W-1:0] cfg_phase = '0;
`endif
  logic [NCH-1:0]   ce, clkout, lock;

  int n_vec = 0;
  int n_miss = 0;
  int k = 0;
  logic [VW-1:0] sb_q[$];
  logic [VW-1:0] exp_v;
  logic [VW-1:0] dut_v;
  logic exp_ce, exp_clk, exp_lk;

  assign dut_v = {cfg_ready, lock, clkout, ce};

  pix_clkgen_dds #(.NCH(NCH), .ACC_W(ACC_W), .LOCK_CYCLES(LOCK_CYCLES), .DEFAULT_INC(DEF)) dut (
    .clkin(clkin), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch), .cfg_inc(cfg_inc),
`ifdef PIX_CLKGEN_PHASE_EN
    .cfg_phase(cfg_phase),
`endif
    .ce(ce), .clkout(clkout), .lock(lock)
  );

  always #5 clkin = ~clkin;

  // reference model
  logic [ACC_W-1:0] m_acc[NCH], m_inc[NCH], m_pend[NCH], m_ph[NCH];
  int               m_st[NCH];
  int               m_cnt[NCH];
  logic [NCH-1:0]   m_ce, m_clk, m_lock, m_arm;
  logic             m_ready, m_rdy_now;
  logic [ACC_W:0]   m_sum;

  always @(posedge clkin) begin
    if (reset) begin
      for (int c = 0; c < NCH; c++) begin
        m_acc[c] = '0; m_inc[c] = DEF; m_pend[c] = '0; m_ph[c] = '0; m_st[c] = 2; m_cnt[c] = 0;
      end
      m_ce = '0; m_clk = '0; m_lock = '0; m_arm = '0; m_ready = 1'b0;
    end else begin
      m_rdy_now = m_ready;
      for (int c = 0; c < NCH; c++) begin
        m_sum = {1'b0, m_acc[c]} + {1'b0, m_inc[c]};
        m_ce[c] = m_sum[ACC_W];
        m_clk[c] = m_sum[ACC_W-1];
        m_acc[c] = m_sum[ACC_W-1:0];
        if (m_arm[c]) m_lock[c] = 1'b1;
        m_arm[c] = 1'b0;
        if (cfg_valid && m_rdy_now && cfg_ch == 2'(c)) begin
          m_pend[c] = cfg_inc;
`ifdef PIX_CLKGEN_PHASE_EN
          m_ph[c] = cfg_phase;
`endif
          m_lock[c] = 1'b0; m_cnt[c] = 0; m_st[c] = 1;
        end else if (m_st[c] == 1 && (m_sum[ACC_W] || m_inc[c] == '0)) begin
          m_inc[c] = m_pend[c]; m_st[c] = 2;
`ifdef PIX_CLKGEN_PHASE_EN
          m_acc[c] = m_ph[c];
`endif
        end else if (m_st[c] == 2 && m_sum[ACC_W]) begin
          // lock follows one edge after the carry whose ce completes the count
          m_cnt[c]++;
          if (m_cnt[c] == LOCK_CYCLES) begin m_arm[c] = 1'b1; m_st[c] = 0; end
        end
      end
      m_ready = 1'b1;
      for (int c = 0; c < NCH; c++) if (m_st[c] == 1) m_ready = 1'b0;
    end
    sb_q.push_back({m_ready, m_lock, m_clk, m_ce});
  end

  task automatic test_reset(input int ncyc);
    reset = 1'b1; cfg_valid = 1'b0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clkin);
      if (sb_q.size() == 0) begin n_miss++; $display("FAIL sb_empty t=%0t", $time); end
      else begin exp_v = sb_q.pop_front(); n_vec++;
        if (dut_v !== exp_v) begin n_miss++; $display("FAIL sb_reset got %h want %h t=%0t", dut_v, exp_v, $time); end end
      n_vec++;
      if (dut_v !== '0) begin n_miss++; $display("FAIL reset_state got %h want 0", dut_v); end
    end
    reset = 1'b0; k = 0;
  endtask

  task automatic test_default_timing();
    for (int i = 1; i <= 70; i++) begin
      @(negedge clkin); k++;
      if (sb_q.size() == 0) begin n_miss++; $display("FAIL sb_empty t=%0t", $time); end
      else begin exp_v = sb_q.pop_front(); n_vec++;
        if (dut_v !== exp_v) begin n_miss++; $display("FAIL sb_default got %h want %h t=%0t", dut_v, exp_v, $time); end end
      exp_ce = (i % 4 == 0); exp_clk = (i % 4 >= 2); exp_lk = (i >= 65);
      n_vec++;
      if ({ce, clkout, lock, cfg_ready} !== {{NCH{exp_ce}}, {NCH{exp_clk}}, {NCH{exp_lk}}, 1'b1}) begin
        n_miss++;
        $display("FAIL default_timing cyc %0d got ce=%b clk=%b lock=%b rdy=%b want ce=%b clk=%b lock=%b rdy=1",
                 i, ce, clkout, lock, cfg_ready, exp_ce, exp_clk, exp_lk);
      end
    end
  endtask

  task automatic test_rate_change();
    cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_inc = 24'h800000;
    for (int i = 0; i < 40; i++) begin
      @(negedge clkin); k++;
      if (sb_q.size() == 0) begin n_miss++; $display("FAIL sb_empty t=%0t", $time); end
      else begin exp_v = sb_q.pop_front(); n_vec++;
        if (dut_v !== exp_v) begin n_miss++; $display("FAIL sb_rate got %h want %h t=%0t", dut_v, exp_v, $time); end end
      cfg_valid = 1'b0;
      if (k == 71) begin n_vec++;
        if ({cfg_ready, lock[0], lock[1]} !== 3'b001) begin n_miss++; $display("FAIL rate_accept got %b want 001", {cfg_ready, lock[0], lock[1]}); end end
      if (k == 72) begin n_vec++;
        if ({cfg_ready, ce[0]} !== 2'b11) begin n_miss++; $display("FAIL rate_apply got %b want 11", {cfg_ready, ce[0]}); end end
      if (k >= 73 && k <= 103) begin n_vec++; exp_ce = (k % 2 == 0); exp_clk = (k % 4 == 0);
        if ({ce[0], ce[1]} !== {exp_ce, exp_clk}) begin n_miss++; $display("FAIL rate_period k=%0d got %b want %b", k, {ce[0], ce[1]}, {exp_ce, exp_clk}); end end
      if (k == 104 || k == 105) begin n_vec++; exp_lk = (k == 105);
        if (lock[0] !== exp_lk) begin n_miss++; $display("FAIL rate_lock k=%0d got %b want %b", k, lock[0], exp_lk); end end
    end
  endtask

  task automatic test_freeze();
    cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_inc = '0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clkin); k++;
      if (sb_q.size() == 0) begin n_miss++; $display("FAIL sb_empty t=%0t", $time); end
      else begin exp_v = sb_q.pop_front(); n_vec++;
        if (dut_v !== exp_v) begin n_miss++; $display("FAIL sb_freeze got %h want %h t=%0t", dut_v, exp_v, $time); end end
      cfg_valid = 1'b0;
      if (k == 111 || k == 120) begin n_vec++;
        if (cfg_ready !== 1'b0) begin n_miss++; $display("FAIL freeze_ready_low k=%0d got %b want 0", k, cfg_ready); end end
      if (k == 112) begin n_vec++;
        if ({cfg_ready, ce[1], clkout[1]} !== 3'b110) begin n_miss++; $display("FAIL freeze_apply got %b want 110", {cfg_ready, ce[1], clkout[1]}); end end
      if (k >= 113 && k <= 119) begin n_vec++;
        if ({ce[1], clkout[1], lock[1]} !== 3'b000) begin n_miss++; $display("FAIL freeze_hold k=%0d got %b want 000", k, {ce[1], clkout[1], lock[1]}); end end
      if (k == 119) begin cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_inc = DEF; end
      if (k == 121) begin n_vec++;
        if ({cfg_ready, ce[1]} !== 2'b10) begin n_miss++; $display("FAIL unfreeze_apply got %b want 10", {cfg_ready, ce[1]}); end end
      if (k >= 122) begin n_vec++; exp_ce = (k >= 125) && ((k - 125) % 4 == 0);
        if (ce[1] !== exp_ce) begin n_miss++; $display("FAIL unfreeze_period k=%0d got %b want %b", k, ce[1], exp_ce); end end
    end
  endtask

  task automatic test_bad_channel();
    cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_inc = 24'h123456;
    for (int i = 0; i < 8; i++) begin
      @(negedge clkin); k++;
      if (sb_q.size() == 0) begin n_miss++; $display("FAIL sb_empty t=%0t", $time); end
      else begin exp_v = sb_q.pop_front(); n_vec++;
        if (dut_v !== exp_v) begin n_miss++; $display("FAIL sb_badch got %h want %h t=%0t", dut_v, exp_v, $time); end end
      cfg_valid = 1'b0;
      exp_ce = (k % 4 == 0);
      n_vec++;
      if ({cfg_ready, lock[2], ce[2]} !== {2'b11, exp_ce}) begin
        n_miss++; $display("FAIL bad_channel k=%0d got %b want %b", k, {cfg_ready, lock[2], ce[2]}, {2'b11, exp_ce});
      end
    end
  endtask

  task automatic test_reset_pending();
    cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_inc = 24'h200000;
    @(negedge clkin); k++;
    if (sb_q.size() == 0) begin n_miss++; $display("FAIL sb_empty t=%0t", $time); end
    else begin exp_v = sb_q.pop_front(); n_vec++;
      if (dut_v !== exp_v) begin n_miss++; $display("FAIL sb_rstpend got %h want %h t=%0t", dut_v, exp_v, $time); end end
    cfg_valid = 1'b0;
    n_vec++;
    if ({cfg_ready, lock[0]} !== 2'b00) begin n_miss++; $display("FAIL pending_before_reset got %b want 00", {cfg_ready, lock[0]}); end
    test_reset(1);
    test_default_timing();
  endtask

`ifdef PIX_CLKGEN_PHASE_EN
  task automatic test_phase_lockstep();
    for (int c = 0; c < 2; c++) begin
      cfg_valid = 1'b1; cfg_ch = 2'(c); cfg_inc = '0; cfg_phase = '0;
      for (int t = 0; t < 12 && (t == 0 || cfg_ready !== 1'b1); t++) begin
        @(negedge clkin);
        if (sb_q.size() == 0) begin n_miss++; $display("FAIL sb_empty t=%0t", $time); end
        else begin exp_v = sb_q.pop_front(); n_vec++;
          if (dut_v !== exp_v) begin n_miss++; $display("FAIL sb_phase got %h want %h t=%0t", dut_v, exp_v, $time); end end
        cfg_valid = 1'b0;
      end
      n_vec++;
      if (cfg_ready !== 1'b1) begin n_miss++; $display("FAIL phase_ready_timeout got %b want 1", cfg_ready); end
    end
    cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_inc = DEF; cfg_phase = '0;
    for (int i = 1; i <= 26; i++) begin
      @(negedge clkin);
      if (sb_q.size() == 0) begin n_miss++; $display("FAIL sb_empty t=%0t", $time); end
      else begin exp_v = sb_q.pop_front(); n_vec++;
        if (dut_v !== exp_v) begin n_miss++; $display("FAIL sb_phase got %h want %h t=%0t", dut_v, exp_v, $time); end end
      cfg_valid = 1'b0;
      if (i == 4) begin cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_inc = DEF; cfg_phase = '0; end
      if (i >= 7) begin n_vec++; exp_ce = ((i - 6) % 4 == 0);
        if ({ce[0], clkout[0], ce[1], clkout[1]} !== {exp_ce, clkout[1], exp_ce, clkout[0]}) begin
          n_miss++; $display("FAIL phase_lockstep i=%0d got ce=%b clk=%b want ce0=ce1=%b clk equal", i, ce[1:0], clkout[1:0], exp_ce);
        end
      end
    end
  endtask
`endif

  initial begin
    test_reset(3);
    test_default_timing();
    test_rate_change();
    test_freeze();
    test_bad_channel();
    test_reset_pending();
`ifdef PIX_CLKGEN_PHASE_EN
    test_phase_lockstep();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1);
  end

endmodule
